// File: rtl/scoreboard_pkg.sv
// Shared constants, record type and status classification for the scoreboard display.
package scoreboard_pkg;

    localparam logic [3:0] ST_DQ         = 4'b0000;
    localparam logic [3:0] ST_RACING     = 4'b1000;
    localparam logic [3:0] ST_PLACE_BASE = 4'b1001;
    localparam logic [3:0] ST_PLACE_LAST = 4'b1100;

    localparam logic [1:0] RL_RED = 2'b10;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    typedef struct packed {
        logic [3:0] pos;
        logic [3:0] status;
    } record_t;

    typedef enum logic [1:0] {
        KIND_HEX,
        KIND_PLACE,
        KIND_DQ,
        KIND_OFF
    } glyph_kind_e;

    function automatic glyph_kind_e classify(input logic [3:0] status);
        if (status == ST_RACING)
            return KIND_HEX;
        else if (status >= ST_PLACE_BASE && status <= ST_PLACE_LAST)
            return KIND_PLACE;
        else if (!status[3])
            return KIND_DQ;
        else
            return KIND_OFF;
    endfunction

endpackage

// File: rtl/scoreboard_display_if.sv
// Game-stage-to-display signal bundle; master is the game stage, slave is the display.
interface scoreboard_display_if;
    logic [1:0] in_player_sel;
    logic [3:0] in_position;
    logic [3:0] in_status_code;
    logic [1:0] in_red_light;
    logic [6:0] out_seg;
    logic       out_dp;
    logic [3:0] out_an;
    logic       out_red_led;

    modport master (
        output in_player_sel, in_position, in_status_code, in_red_light,
        input  out_seg, out_dp, out_an, out_red_led
    );

    modport slave (
        input  in_player_sel, in_position, in_status_code, in_red_light,
        output out_seg, out_dp, out_an, out_red_led
    );
endinterface

// File: rtl/seg7_encoder.sv
// Hex value to active-low seven-segment glyph {g,f,e,d,c,b,a}.
module seg7_encoder (
    input  logic [3:0] val,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (val)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/scoreboard_display.sv
// Four-digit multiplexed scoreboard: captures per-player records and scans them out.
// Optional macro SCOREBOARD_BLINK_EN blinks disqualified digits.
module scoreboard_display
    import scoreboard_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_HALF  = 250000
) (
    input  logic clk,
    input  logic rst,
    scoreboard_display_if.slave bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be at least 1");
    end

    logic [1:0]          sel_prev_q, sel_prev_d;
    record_t [3:0]       rec_q, rec_d;
    logic [RW-1:0]       refresh_q, refresh_d;
    logic [1:0]          digit_q, digit_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                red_q, red_d;
    logic                blink_vis;
    logic [1:0]          slot;
    record_t             cur;
    logic [3:0]          enc_val;
    logic [6:0]          enc_seg;

`ifdef SCOREBOARD_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // phase_q = 1 is the visible half; reset starts visible
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_vis = phase_q;
`else
    assign blink_vis = 1'b1;
`endif

    seg7_encoder u_enc (
        .val (enc_val),
        .seg (enc_seg)
    );

    always_comb begin
        sel_prev_d = bus.in_player_sel;
        rec_d      = rec_q;
        // the stage reports the player it just left, hence the minus one
        slot       = bus.in_player_sel - 2'd1;
        if (bus.in_player_sel != sel_prev_q)
            rec_d[slot] = '{pos: bus.in_position, status: bus.in_status_code};

        refresh_d = refresh_q + 1'b1;
        digit_d   = digit_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = digit_q + 2'd1;
        end

        cur     = rec_q[digit_q];
        enc_val = (classify(cur.status) == KIND_PLACE) ? {1'b0, cur.status[2:0]} : cur.pos;
        an_d    = ~(4'b0001 << digit_q);
        seg_d   = GLYPH_BLANK;
        dp_d    = 1'b1;
        case (classify(cur.status))
            KIND_HEX:   seg_d = enc_seg;
            KIND_PLACE: begin
                seg_d = enc_seg;
                dp_d  = 1'b0;
            end
            KIND_DQ:    seg_d = blink_vis ? GLYPH_DASH : GLYPH_BLANK;
            default:    seg_d = GLYPH_BLANK;
        endcase

        red_d = (bus.in_red_light == RL_RED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_prev_q <= 2'b00;
            for (int i = 0; i < 4; i++)
                rec_q[i] <= '{pos: 4'b0000, status: ST_RACING};
            refresh_q  <= '0;
            digit_q    <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= GLYPH_BLANK;
            dp_q       <= 1'b1;
            red_q      <= 1'b0;
        end else begin
            sel_prev_q <= sel_prev_d;
            rec_q      <= rec_d;
            refresh_q  <= refresh_d;
            digit_q    <= digit_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            red_q      <= red_d;
        end
    end

    assign bus.out_an      = an_q;
    assign bus.out_seg     = seg_q;
    assign bus.out_dp      = dp_q;
    assign bus.out_red_led = red_q;
endmodule

// File: tb/tb_scoreboard_display.sv
// Bench for scoreboard_display: cycle-level reference model plus directed and random stimulus.
module tb_scoreboard_display;
    localparam int RDIV = 4;
    // 6 rather than 8: with RDIV=4 a half-period of 8 would keep digit 3 always in the hidden phase
    localparam int BH   = 6;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    scoreboard_display_if bus ();

    scoreboard_display #(.REFRESH_DIV(RDIV), .BLINK_HALF(BH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: records as plain arrays, scan position derived from cycles since reset.
    logic [3:0] m_pos [4];
    logic [3:0] m_st  [4];
    logic [1:0] m_prev;
    int         m_cyc;
    int         m_dig;
    int         m_slot;
    logic       m_vis;
    logic       m_valid = 1'b0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_red;

    always @(posedge clk) begin
        if (rst) begin
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_red = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_pos[i] = 4'd0;
                m_st[i]  = 4'd8;
            end
            m_prev = 2'd0; m_cyc = 0; m_valid = 1'b1;
        end else begin
            m_dig = (m_cyc / RDIV) % 4;
`ifdef SCOREBOARD_BLINK_EN
            m_vis = ((m_cyc / BH) % 2) == 0;
`else
            m_vis = 1'b1;
`endif
            e_an = 4'b1111;
            e_an[m_dig] = 1'b0;
            e_dp = 1'b1;
            if (m_st[m_dig] == 4'd8)
                e_seg = HEX_TBL[m_pos[m_dig]];
            else if (m_st[m_dig] >= 4'd9 && m_st[m_dig] <= 4'd12) begin
                e_seg = HEX_TBL[m_st[m_dig] - 4'd8];
                e_dp  = 1'b0;
            end else if (m_st[m_dig] < 4'd8)
                e_seg = m_vis ? 7'b0111111 : 7'b1111111;
            else
                e_seg = 7'b1111111;
            e_red = (bus.in_red_light == 2'b10);
            if (bus.in_player_sel != m_prev) begin
                m_slot = (int'(bus.in_player_sel) + 3) % 4;
                m_pos[m_slot] = bus.in_position;
                m_st[m_slot]  = bus.in_status_code;
            end
            m_prev = bus.in_player_sel;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model an",  bus.out_an,  e_an);
            check("model seg", bus.out_seg, e_seg);
            check("model dp",  bus.out_dp,  e_dp);
            check("model red", bus.out_red_led, e_red);
        end
    end

    task automatic wait_an(input logic [3:0] an, input int budget, input string nm);
        int k = 0;
        while (bus.out_an !== an && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, bus.out_an, an);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [3:0] pos, input logic [3:0] st);
        bus.in_player_sel  = sel;
        bus.in_position    = pos;
        bus.in_status_code = st;
    endtask

    initial begin
        logic saw_dash, saw_blank;
        drive(2'd0, 4'd0, 4'd8);
        bus.in_red_light = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset an",  bus.out_an,  4'b1111);
        check("reset seg", bus.out_seg, 7'b1111111);
        check("reset dp",  bus.out_dp,  1'b1);
        check("reset red", bus.out_red_led, 1'b0);

        rst = 1'b0;
        @(negedge clk);
        check("release an",  bus.out_an,  4'b1110);
        check("release seg", bus.out_seg, 7'b1000000);

        drive(2'd1, 4'd5, 4'd8);
        @(negedge clk);
        drive(2'd1, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        wait_an(4'b1110, 40, "pos wait");
        check("pos seg", bus.out_seg, 7'b0010010);
        check("pos dp",  bus.out_dp,  1'b1);

        drive(2'd2, 4'd0, 4'd8);
        @(negedge clk);
        drive(2'd3, 4'd0, 4'd9);
        @(negedge clk);
        repeat (2) @(negedge clk);
        wait_an(4'b1011, 40, "place wait");
        check("place seg", bus.out_seg, 7'b1111001);
        check("place dp",  bus.out_dp,  1'b0);

        drive(2'd0, 4'd0, 4'd0);
        @(negedge clk);
        repeat (2) @(negedge clk);
`ifdef SCOREBOARD_BLINK_EN
        saw_dash = 1'b0;
        saw_blank = 1'b0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (bus.out_an == 4'b0111) begin
                if (bus.out_seg == 7'b0111111) saw_dash = 1'b1;
                if (bus.out_seg == 7'b1111111) saw_blank = 1'b1;
            end
        end
        check("blink dash seen",  saw_dash,  1'b1);
        check("blink blank seen", saw_blank, 1'b1);
`else
        wait_an(4'b0111, 40, "dq wait");
        check("dq seg", bus.out_seg, 7'b0111111);
        check("dq dp",  bus.out_dp,  1'b1);
`endif

        bus.in_red_light = 2'b10;
        @(negedge clk);
        check("red on", bus.out_red_led, 1'b1);
        bus.in_red_light = 2'b01;
        @(negedge clk);
        check("red off", bus.out_red_led, 1'b0);

        drive(2'd2, 4'd7, 4'd8);
        @(negedge clk);
        drive(2'd2, 4'd0, 4'd8);
        repeat (2) @(negedge clk);
        wait_an(4'b1101, 40, "pos7 wait");
        check("pos7 seg", bus.out_seg, 7'b1111000);
        wait_an(4'b1011, 40, "midscan wait");
        rst = 1'b1;
        drive(2'd0, 4'd0, 4'd8);
        @(negedge clk);
        check("midrst an",  bus.out_an,  4'b1111);
        check("midrst seg", bus.out_seg, 7'b1111111);
        check("midrst dp",  bus.out_dp,  1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("resume an", bus.out_an, 4'b1110);
        wait_an(4'b1101, 40, "slot1 wait");
        check("slot1 seg", bus.out_seg, 7'b1000000);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0)
                bus.in_player_sel = 2'($urandom_range(0, 3));
            bus.in_position = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: bus.in_status_code = 4'd8;
                1: bus.in_status_code = 4'($urandom_range(9, 12));
                2: bus.in_status_code = 4'($urandom_range(0, 7));
                default: bus.in_status_code = 4'($urandom_range(13, 15));
            endcase
            bus.in_red_light = 2'($urandom_range(0, 3));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
